hazard_ctrl: RTL

- Pipeline control unit for the five-stage core.
- Consumes the EX-side outputs of the ID/EX register (rd, wb_select, pc_sel) and the ID-side source registers.
- Produces the stall, flush and bubble controls that drive the PC, IF/ID, ID/EX and EX/MEM registers.
- Tracks validity of the instruction in EX and sequences branch/jump flushes and data-memory wait freezes.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline control unit for the five-stage core. It generates the
//            stall, flush and bubble controls for the PC, IF/ID, ID/EX and
//            EX/MEM registers. It also tracks whether EX holds a real
//            instruction, and it sequences branch/jump flushes and data-memory
//            wait freezes.
// Option   : `define HAZARD_PERF_EN to add the perf_lu_cnt, perf_flush_cnt and
//            perf_memwait_cnt event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [1:0]  LOAD_WB_SEL  = 2'b01
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic        id_rs1_used,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb_select,
    input  logic        ex_pc_sel,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_bubble,
    output logic        exmem_stall,
    output logic        ex_valid,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt,
`endif
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // After the redirect cycle itself, FLUSH_CYCLES-1 squash cycles remain.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ex_valid_q, ex_valid_d;
    logic       lu_hit, redir;

    // The hazard terms are only meaningful while EX holds a real instruction.
    // A load that targets x0 never causes a stall.
    assign lu_hit = id_valid & ex_valid_q & (ex_wb_select == LOAD_WB_SEL) & (ex_rd != 5'd0)
                  & ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    assign redir  = ex_valid_q & ex_pc_sel;

    // Update the state, the flush counter and the EX-valid flag.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // Compute the next state and the controls. Priority is mem_busy, then
    // redirect, then load-use. All controls stay low while in reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_valid_d  = ex_valid_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_bubble = 1'b0;
        exmem_stall = 1'b0;
        if (sys_rst) begin
            if (mem_busy) begin
                // Freeze the whole pipeline. In FLUSH the counter is kept,
                // and the remaining squash cycles resume once dmem is ready.
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                if (state_q != ST_FLUSH) begin
                    state_d = ST_MEM_WAIT;
                end
            end else if (state_q == ST_FLUSH) begin
                // In FLUSH, ID and EX hold wrong-path instructions, so any
                // hazards reported for them are ignored.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                ex_valid_d  = 1'b0;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end else begin
                // RUN, or MEM_WAIT after dmem becomes ready. The instruction
                // held in EX is evaluated now, so a pending redirect is not lost.
                state_d = ST_RUN;
                if (redir) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    ex_valid_d  = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = FLUSH_INIT;
                        state_d = ST_FLUSH;
                    end
                end else if (lu_hit) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    ex_valid_d  = 1'b0;
                end else begin
                    ex_valid_d  = id_valid;
                end
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_EN
    // Count load-use stall cycles, redirect events and memory-freeze cycles.
    // Only a load-use stall raises pc_stall without also raising idex_stall.
    // A redirect is counted once, on the flush cycle that occurs outside FLUSH.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            perf_lu_cnt      <= 32'd0;
            perf_flush_cnt   <= 32'd0;
            perf_memwait_cnt <= 32'd0;
        end else begin
            if (pc_stall & ~idex_stall) begin
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            end
            if (ifid_flush & (state_q != ST_FLUSH)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (exmem_stall) begin
                perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
